// File: rtl/bram_init_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bram_init_pkg
//  Description : Shared types for the BRAM initialisation sequencer: the job
//                mode encoding, the controller state encoding and the decoder
//                that maps the raw two-bit cfg_mode field onto a mode.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package bram_init_pkg;

   typedef enum logic [1:0] {
      MODE_FILL = 2'b00,
      MODE_INCR = 2'b01,
      MODE_COPY = 2'b10
   } mode_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_DRAIN = 2'b10,
      ST_DONE  = 2'b11
   } state_e;

   // The reserved encoding 2'b11 behaves exactly like FILL.
   function automatic mode_e decode_mode(input logic [1:0] raw);
      mode_e m;
      m = MODE_FILL;
      case (raw)
         2'b01:   m = MODE_INCR;
         2'b10:   m = MODE_COPY;
         default: m = MODE_FILL;
      endcase
      return m;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bram_init_delay.sv
`default_nettype none
// ============================================================================
//  Module      : bram_init_delay
//  Description : Fixed-depth shift register that carries a valid flag and the
//                destination write address of every source read request, so
//                the matching write can be issued exactly SRC_LAT cycles later
//                when the source data arrives.
//  Ports       : clk        - clock, posedge
//                rst_n      - asynchronous active-low reset
//                in_valid   - a source read is issued this cycle
//                in_addr    - destination address for that read
//                out_valid  - the read issued SRC_LAT cycles ago returns now
//                out_addr   - destination address for the returning word
//                pending    - a request is still in flight behind the output
//  Revision    : 1.0  initial release
// ============================================================================
module bram_init_delay #(
   parameter int SRC_LAT = 2,
   parameter int ADDR_W  = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [ADDR_W-1:0] in_addr,
   output logic              out_valid,
   output logic [ADDR_W-1:0] out_addr,
   output logic              pending
);

   logic [SRC_LAT-1:0] vld;
   logic [ADDR_W-1:0]  adr [SRC_LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld <= '0;
         for (int k = 0; k < SRC_LAT; k++) begin
            adr[k] <= '0;
         end
      end else begin
         vld[0] <= in_valid;
         adr[0] <= in_addr;
         for (int k = 1; k < SRC_LAT; k++) begin
            vld[k] <= vld[k-1];
            adr[k] <= adr[k-1];
         end
      end
   end

   assign out_valid = vld[SRC_LAT-1];
   assign out_addr  = adr[SRC_LAT-1];

   // Only stages ahead of the output count: when the output stage holds the
   // last request, the write happens this cycle and the pipe is empty next.
   always_comb begin
      pending = 1'b0;
      for (int k = 0; k < SRC_LAT - 1; k++) begin
         pending = pending | vld[k];
      end
   end

endmodule
`default_nettype wire

// File: rtl/bram_init_seq.sv
`default_nettype none
// ============================================================================
//  Module      : bram_init_seq
//  Description : Sequencer that initialises a simple-dual-port BRAM through
//                its write port. A job writes cfg_count consecutive words
//                starting at cfg_base (addresses wrap) with either a constant
//                (FILL), a masked incrementing pattern (INCR) or words read
//                from a source memory with fixed latency SRC_LAT (COPY).
//  Ports       : MEMORY_CLK          - sole clock, posedge
//                rst_n               - asynchronous active-low reset
//                start               - job request, sampled in IDLE only
//                cfg_mode/base/count/value/mask/src - job description
//                wr_ce/wr_addr/wr_data - BRAM write port
//                src_ce/src_addr     - source read request
//                src_data            - source read data (SRC_LAT cycles later)
//                busy                - job in progress
//                done                - one-cycle pulse after the last write
//  Revision    : 1.0  initial release
// ============================================================================
module bram_init_seq
   import bram_init_pkg::*;
#(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 8,
   parameter int SRC_LAT    = 2,
   parameter int AUTO_START = 1
) (
   input  logic              MEMORY_CLK,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        cfg_mode,
   input  logic [ADDR_W-1:0] cfg_base,
   input  logic [ADDR_W:0]   cfg_count,
   input  logic [DATA_W-1:0] cfg_value,
   input  logic [DATA_W-1:0] cfg_mask,
   input  logic [ADDR_W-1:0] cfg_src,
   output logic              wr_ce,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              src_ce,
   output logic [ADDR_W-1:0] src_addr,
   input  logic [DATA_W-1:0] src_data,
   output logic              busy,
   output logic              done
);

   localparam logic [ADDR_W:0] COUNT_ONE = (ADDR_W+1)'(1);

   state_e            state;
   state_e            state_nxt;
   logic              auto_pend;
   logic              accept;
   logic              last_issue;

   // Latched job description
   mode_e             mode_q;
   logic [ADDR_W-1:0] base_q;
   logic [ADDR_W-1:0] src_q;
   logic [ADDR_W:0]   count_q;
   logic [DATA_W-1:0] value_q;
   logic [DATA_W-1:0] mask_q;

   // Number of items (writes or reads) issued so far, including the one
   // presented in the current RUN cycle.
   logic [ADDR_W:0]   issued;

   logic              fill_ce_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic [DATA_W-1:0] wr_data_q;
   logic              src_ce_q;
   logic [ADDR_W-1:0] src_addr_q;
   logic [ADDR_W-1:0] dst_addr_q;

   logic              dly_valid;
   logic [ADDR_W-1:0] dly_addr;
   logic              dly_pending;

   function automatic logic [DATA_W-1:0] gen_word(
      input mode_e             m,
      input logic [DATA_W-1:0] v,
      input logic [DATA_W-1:0] msk,
      input logic [ADDR_W:0]   idx
   );
      logic [DATA_W-1:0] sum;
      sum = v + DATA_W'(idx);
      return (m == MODE_INCR) ? (sum & msk) : v;
   endfunction

   // The auto-start flag turns the first cycle after reset release into an
   // accepted start using whatever cfg_* values are present then.
   assign accept     = (state == ST_IDLE) && (start || auto_pend);
   assign last_issue = (issued == count_q);

   // ------------------------------------------------------------------
   // Controller
   // ------------------------------------------------------------------
   always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt = (cfg_count == '0) ? ST_DONE : ST_RUN;
            end
         end
         ST_RUN: begin
            busy = 1'b1;
            if (last_issue) begin
               state_nxt = (mode_q == MODE_COPY) ? ST_DRAIN : ST_DONE;
            end
         end
         ST_DRAIN: begin
            busy = 1'b1;
            if (!dly_pending) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath: the first item is loaded on the accepting edge so the
   // first write/read appears in the first RUN cycle.
   // ------------------------------------------------------------------
   always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
      if (!rst_n) begin
         auto_pend  <= (AUTO_START != 0);
         mode_q     <= MODE_FILL;
         base_q     <= '0;
         src_q      <= '0;
         count_q    <= '0;
         value_q    <= '0;
         mask_q     <= '0;
         issued     <= '0;
         fill_ce_q  <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         src_ce_q   <= 1'b0;
         src_addr_q <= '0;
         dst_addr_q <= '0;
      end else begin
         auto_pend <= 1'b0;
         if (accept) begin
            mode_q  <= decode_mode(cfg_mode);
            base_q  <= cfg_base;
            src_q   <= cfg_src;
            count_q <= cfg_count;
            value_q <= cfg_value;
            mask_q  <= cfg_mask;
            issued  <= COUNT_ONE;
            if (cfg_count != '0) begin
               if (decode_mode(cfg_mode) == MODE_COPY) begin
                  src_ce_q   <= 1'b1;
                  src_addr_q <= cfg_src;
                  dst_addr_q <= cfg_base;
               end else begin
                  fill_ce_q <= 1'b1;
                  wr_addr_q <= cfg_base;
                  wr_data_q <= gen_word(decode_mode(cfg_mode), cfg_value,
                                        cfg_mask, '0);
               end
            end
         end else if (state == ST_RUN) begin
            if (last_issue) begin
               fill_ce_q <= 1'b0;
               src_ce_q  <= 1'b0;
            end else begin
               issued <= issued + COUNT_ONE;
               if (mode_q == MODE_COPY) begin
                  src_addr_q <= src_q + issued[ADDR_W-1:0];
                  dst_addr_q <= base_q + issued[ADDR_W-1:0];
               end else begin
                  wr_addr_q <= base_q + issued[ADDR_W-1:0];
                  wr_data_q <= gen_word(mode_q, value_q, mask_q, issued);
               end
            end
         end
         // Remember the last COPY write so the port holds it afterwards.
         if (dly_valid) begin
            wr_addr_q <= dly_addr;
            wr_data_q <= src_data;
         end
      end
   end

   bram_init_delay #(
      .SRC_LAT (SRC_LAT),
      .ADDR_W  (ADDR_W)
   ) u_delay (
      .clk       (MEMORY_CLK),
      .rst_n     (rst_n),
      .in_valid  (src_ce_q),
      .in_addr   (dst_addr_q),
      .out_valid (dly_valid),
      .out_addr  (dly_addr),
      .pending   (dly_pending)
   );

   // COPY writes bypass the hold registers so the returning word is written
   // in the very cycle it is valid on src_data.
   assign wr_ce    = fill_ce_q | dly_valid;
   assign wr_addr  = dly_valid ? dly_addr : wr_addr_q;
   assign wr_data  = dly_valid ? src_data : wr_data_q;
   assign src_ce   = src_ce_q;
   assign src_addr = src_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_init_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bram_init_seq
//  Description : Self-checking bench for bram_init_seq. A source ROM model
//                answers reads after LAT cycles, a monitor applies every DUT
//                write to a memory image, and a job-level reference model
//                builds the expected image from the job rules.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bram_init_seq;

   localparam int AW    = 10;
   localparam int DW    = 8;
   localparam int LAT   = 2;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [1:0]    cfg_mode;
   logic [AW-1:0] cfg_base;
   logic [AW:0]   cfg_count;
   logic [DW-1:0] cfg_value;
   logic [DW-1:0] cfg_mask;
   logic [AW-1:0] cfg_src;
   logic          wr_ce;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          src_ce;
   logic [AW-1:0] src_addr;
   logic [DW-1:0] src_data;
   logic          busy;
   logic          done;

   always #5 clk = ~clk;

   bram_init_seq #(
      .ADDR_W     (AW),
      .DATA_W     (DW),
      .SRC_LAT    (LAT),
      .AUTO_START (1)
   ) dut (
      .MEMORY_CLK (clk),
      .rst_n      (rst_n),
      .start      (start),
      .cfg_mode   (cfg_mode),
      .cfg_base   (cfg_base),
      .cfg_count  (cfg_count),
      .cfg_value  (cfg_value),
      .cfg_mask   (cfg_mask),
      .cfg_src    (cfg_src),
      .wr_ce      (wr_ce),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .src_ce     (src_ce),
      .src_addr   (src_addr),
      .src_data   (src_data),
      .busy       (busy),
      .done       (done)
   );

   logic [DW-1:0] rom     [DEPTH];
   logic [DW-1:0] dut_mem [DEPTH];
   logic [DW-1:0] exp_mem [DEPTH];

   // Source memory: data for a read issued in cycle t is valid in cycle t+2;
   // otherwise the bus carries junk.
   logic          a1_v = 1'b0, a2_v = 1'b0;
   logic [AW-1:0] a1 = '0, a2 = '0;
   logic [DW-1:0] junk = '0;
   always @(posedge clk) begin
      a1_v <= src_ce;
      a1   <= src_addr;
      a2_v <= a1_v;
      a2   <= a1;
      junk <= DW'($urandom);
   end
   assign src_data = a2_v ? rom[a2] : junk;

   int cyc = 0;
   int wr_n, wr_first, wr_last, src_n, src_first, busy_n, done_n, done_cyc;
   int checks = 0;
   int failures = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (wr_ce === 1'b1) begin
         dut_mem[wr_addr] = wr_data;
         if (wr_n == 0) wr_first = cyc;
         wr_last = cyc;
         wr_n++;
      end
      if (src_ce === 1'b1) begin
         if (src_n == 0) src_first = cyc;
         src_n++;
      end
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1) begin
         done_n++;
         done_cyc = cyc;
      end
   end

   task automatic clear_mon();
      wr_n = 0; wr_first = -1; wr_last = -1;
      src_n = 0; src_first = -1;
      busy_n = 0; done_n = 0; done_cyc = -1;
   endtask

   // Reference model: word i of a job, from the job rules.
   function automatic logic [DW-1:0] exp_word(int mode, int value, int mask, int src, int i);
      if (mode == 1) return DW'(((value + i) % 256) & mask);
      if (mode == 2) return rom[(src + i) % DEPTH];
      return DW'(value);
   endfunction

   task automatic model_job(int mode, int base, int count, int value, int mask, int src);
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = dut_mem[i];
      for (int i = 0; i < count; i++) exp_mem[(base + i) % DEPTH] = exp_word(mode, value, mask, src, i);
   endtask

   function automatic int image_diff();
      int bad = 0;
      for (int i = 0; i < DEPTH; i++) if (dut_mem[i] !== exp_mem[i]) bad++;
      return bad;
   endfunction

   task automatic drive_cfg(int mode, int base, int count, int value, int mask, int src);
      cfg_mode  = 2'(mode);
      cfg_base  = AW'(base);
      cfg_count = (AW+1)'(count);
      cfg_value = DW'(value);
      cfg_mask  = DW'(mask);
      cfg_src   = AW'(src);
   endtask

   // Returns s = the first cycle after the accepting edge.
   task automatic launch(int mode, int base, int count, int value, int mask, int src, output int s);
      @(negedge clk); #1;
      clear_mon();
      model_job(mode, base, count, value, mask, src);
      drive_cfg(mode, base, count, value, mask, src);
      start = 1'b1;
      @(posedge clk); #1;
      s = cyc;
      start = 1'b0;
   endtask

   task automatic wait_done(int limit, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < limit && !ok; k++) begin
         @(negedge clk); #1;
         if (done_n > 0) ok = 1'b1;
      end
      repeat (4) @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      int s;
      bit ok;
      rst_n = 1'b0; start = 1'b0;
      drive_cfg(0, 0, 0, 0, 0, 0);
      clear_mon();
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({wr_ce, src_ce, busy, done, wr_addr, wr_data, src_addr} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got wr_ce=%b src_ce=%b busy=%b done=%b wr_addr=%h wr_data=%h src_addr=%h, required all 0",
                  wr_ce, src_ce, busy, done, wr_addr, wr_data, src_addr);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      s = cyc;
      wait_done(10, ok);
      checks++;
      if (!ok || done_cyc != s) begin
         failures++;
         $display("FAIL auto_start_zero_done: done at cycle %0d, required %0d", done_cyc, s);
      end
      checks++;
      if (busy_n != 0 || wr_n != 0 || src_n != 0 || done_n != 1) begin
         failures++;
         $display("FAIL auto_start_zero_activity: busy=%0d wr=%0d src=%0d done=%0d, required 0/0/0/1", busy_n, wr_n, src_n, done_n);
      end
   endtask

   task automatic test_incr_full();
      int s;
      bit ok;
      launch(1, 0, 1024, 0, 'h7F, 0, s);
      wait_done(1100, ok);
      checks++;
      if (!ok || done_cyc != s + 1024) begin
         failures++;
         $display("FAIL incr_full_done: done at %0d, required %0d", done_cyc - s + 1, 1025);
      end
      checks++;
      if (wr_n != 1024 || wr_first != s || wr_last != s + 1023) begin
         failures++;
         $display("FAIL incr_full_writes: got n=%0d span %0d..%0d, required 1024 span %0d..%0d", wr_n, wr_first, wr_last, s, s + 1023);
      end
      checks++;
      if (image_diff() != 0) begin
         failures++;
         $display("FAIL incr_full_image: %0d locations differ, required 0", image_diff());
      end
   endtask

   task automatic test_fill_wrap();
      int s;
      bit ok;
      launch(0, 'h3FE, 4, 'hA5, 0, 0, s);
      wait_done(20, ok);
      checks++;
      if (!ok || done_cyc != s + 4 || wr_n != 4 || busy_n != 4) begin
         failures++;
         $display("FAIL fill_wrap_timing: done=%0d wr=%0d busy=%0d, required done=%0d wr=4 busy=4", done_cyc, wr_n, busy_n, s + 4);
      end
      checks++;
      if (image_diff() != 0) begin
         failures++;
         $display("FAIL fill_wrap_image: %0d locations differ, required 0", image_diff());
      end
      checks++;
      if (wr_addr !== 10'h001 || wr_data !== 8'hA5) begin
         failures++;
         $display("FAIL fill_wrap_hold: got addr=%h data=%h, required 001/a5", wr_addr, wr_data);
      end
   endtask

   task automatic test_copy();
      int s;
      bit ok;
      launch(2, 0, 16, 0, 0, 'h100, s);
      wait_done(40, ok);
      checks++;
      if (!ok || wr_first - src_first != 2 || src_first != s) begin
         failures++;
         $display("FAIL copy_latency: src_first=%0d wr_first=%0d, required %0d/%0d", src_first, wr_first, s, s + 2);
      end
      checks++;
      if (busy_n != 18 || done_cyc != s + 18 || wr_n != 16 || src_n != 16) begin
         failures++;
         $display("FAIL copy_timing: busy=%0d done=%0d wr=%0d src=%0d, required 18/%0d/16/16", busy_n, done_cyc, wr_n, src_n, s + 18);
      end
      checks++;
      if (image_diff() != 0) begin
         failures++;
         $display("FAIL copy_image: %0d locations differ, required 0", image_diff());
      end
   endtask

   task automatic test_count_zero();
      int s;
      bit ok;
      launch(2, 'h55, 0, 3, 0, 'h20, s);
      wait_done(10, ok);
      checks++;
      if (!ok || done_cyc != s || done_n != 1 || busy_n != 0 || wr_n != 0 || src_n != 0) begin
         failures++;
         $display("FAIL count_zero: done=%0d n=%0d busy=%0d wr=%0d src=%0d, required done=%0d n=1 others 0", done_cyc, done_n, busy_n, wr_n, src_n, s);
      end
   endtask

   task automatic test_start_ignored();
      int s;
      bit ok;
      launch(1, 'h200, 12, 'h10, 'hFF, 0, s);
      repeat (3) @(negedge clk);
      drive_cfg(0, 'h300, 5, 'hEE, 0, 0);
      start = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
      wait_done(30, ok);
      repeat (6) @(negedge clk);
      #1;
      checks++;
      if (!ok || done_n != 1 || wr_n != 12 || done_cyc != s + 12) begin
         failures++;
         $display("FAIL start_ignored: done_n=%0d wr=%0d done=%0d, required 1/12/%0d", done_n, wr_n, done_cyc, s + 12);
      end
      checks++;
      if (image_diff() != 0) begin
         failures++;
         $display("FAIL start_ignored_image: %0d locations differ, required 0", image_diff());
      end
   endtask

   task automatic test_random();
      int s, mode, base, count, value, mask, src, lat;
      bit ok;
      for (int j = 0; j < 10; j++) begin
         mode  = $urandom_range(0, 3);
         base  = $urandom_range(0, DEPTH - 1);
         count = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 40);
         value = $urandom_range(0, 255);
         mask  = $urandom_range(0, 255);
         src   = $urandom_range(0, DEPTH - 1);
         lat   = (mode == 2) ? LAT : 0;
         launch(mode, base, count, value, mask, src, s);
         wait_done(count + 20, ok);
         checks++;
         if (!ok || done_n != 1 || done_cyc != ((count == 0) ? s : s + count + lat)) begin
            failures++;
            $display("FAIL random[%0d] done: at %0d n=%0d, required %0d n=1 (mode=%0d count=%0d)", j, done_cyc, done_n,
                     (count == 0) ? s : s + count + lat, mode, count);
         end
         checks++;
         if (wr_n != count || src_n != ((mode == 2) ? count : 0) || busy_n != ((count == 0) ? 0 : count + lat)) begin
            failures++;
            $display("FAIL random[%0d] counts: wr=%0d src=%0d busy=%0d (mode=%0d count=%0d)", j, wr_n, src_n, busy_n, mode, count);
         end
         if (count > 0) begin
            checks++;
            if (wr_first != s + lat || wr_last != s + lat + count - 1) begin
               failures++;
               $display("FAIL random[%0d] span: got %0d..%0d, required %0d..%0d", j, wr_first, wr_last, s + lat, s + lat + count - 1);
            end
         end
         checks++;
         if (image_diff() != 0) begin
            failures++;
            $display("FAIL random[%0d] image: %0d locations differ, required 0 (mode=%0d)", j, image_diff(), mode);
         end
      end
   endtask

   task automatic test_reset_mid_copy();
      int s, value, mask;
      bit ok;
      launch(2, 'h080, 60, 0, 0, 'h3C0, s);
      repeat (10) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({wr_ce, src_ce, busy, done, wr_addr, wr_data, src_addr} !== '0) begin
         failures++;
         $display("FAIL mid_reset_outputs: got wr_ce=%b src_ce=%b busy=%b done=%b wr_addr=%h wr_data=%h src_addr=%h, required all 0",
                  wr_ce, src_ce, busy, done, wr_addr, wr_data, src_addr);
      end
      value = $urandom_range(0, 255);
      mask  = $urandom_range(1, 255);
      repeat (2) @(negedge clk);
      #1;
      clear_mon();
      model_job(1, 'h3F0, 20, value, mask, 0);
      drive_cfg(1, 'h3F0, 20, value, mask, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      s = cyc;
      wait_done(40, ok);
      repeat (6) @(negedge clk);
      #1;
      checks++;
      if (!ok || done_n != 1 || wr_n != 20 || src_n != 0 || wr_first != s || done_cyc != s + 20) begin
         failures++;
         $display("FAIL mid_reset_autojob: done_n=%0d wr=%0d src=%0d first=%0d done=%0d, required 1/20/0/%0d/%0d",
                  done_n, wr_n, src_n, wr_first, done_cyc, s, s + 20);
      end
      checks++;
      if (image_diff() != 0) begin
         failures++;
         $display("FAIL mid_reset_image: %0d locations differ, required 0", image_diff());
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) begin
         rom[i]     = DW'($urandom);
         dut_mem[i] = DW'($urandom);
         exp_mem[i] = dut_mem[i];
      end
      test_reset();
      test_incr_full();
      test_fill_wrap();
      test_copy();
      test_count_zero();
      test_start_ignored();
      test_random();
      test_reset_mid_copy();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
